// File: rtl/vend_pkg.sv
// Shared encodings and elaboration-time parameter check for the vending FSM.
package vend_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_CHANGE = 1'b1
  } state_t;

  localparam int HALF_W = 1;
  localparam int ONE_W  = 2;

  // Credit must hold PRICE-1 plus a double coin (3) without overflow.
  function automatic bit params_ok(int price, int cred_w, int cnt_w);
    return (price >= 1) && (cred_w >= 2) && (cred_w < 31) &&
           ((price + 2) < (1 << cred_w)) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/vend_sale_cnt.sv
// Free-running sales counter; wraps silently at 2^CNT_W.
module vend_sale_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  cnt <= '0;
    else if (inc)    cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/vend_fsm_param.sv
// Single-item vending FSM: accepts 0.5/1 coins, vends at PRICE, pays change
// or refunds serially as 0.5-unit pulses, rejects coins while paying out.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int PRICE  = 5,
  parameter int CRED_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              pi_half,
  input  logic              pi_one,
  input  logic              pi_cancel,
  output logic              po_cola,
  output logic              po_half,
  output logic              po_reject,
  output logic              po_busy,
  output logic [CRED_W-1:0] po_credit,
  output logic [CNT_W-1:0]  po_sold_cnt
);

  if (!params_ok(PRICE, CRED_W, CNT_W)) begin : g_bad_params
    $error("vend_fsm_param: illegal PRICE/CRED_W/CNT_W combination");
  end

  // One spare bit so credit+coin compares cleanly against PRICE.
  localparam int              SW      = CRED_W + 1;
  localparam logic [SW-1:0]   PRICE_V = SW'(PRICE);

  state_t            state, state_nx;
  logic [CRED_W-1:0] credit, credit_nx;
  logic              cola_nx, half_nx, reject_nx, sale;
  logic [SW-1:0]     coin_v, total;

  assign coin_v = (pi_half ? SW'(HALF_W) : '0) + (pi_one ? SW'(ONE_W) : '0);
  assign total  = SW'(credit) + coin_v;

  always_comb begin
    state_nx  = state;
    credit_nx = credit;
    cola_nx   = 1'b0;
    half_nx   = 1'b0;
    reject_nx = 1'b0;
    sale      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pi_cancel) begin
          // Cancel wins over a sale: everything inserted so far is refunded.
          if (total != '0) begin
            credit_nx = CRED_W'(total);
            state_nx  = ST_CHANGE;
          end
        end else if (total >= PRICE_V) begin
          cola_nx   = 1'b1;
          sale      = 1'b1;
          credit_nx = CRED_W'(total - PRICE_V);
          if (total != PRICE_V) state_nx = ST_CHANGE;
        end else begin
          credit_nx = CRED_W'(total);
        end
      end
      ST_CHANGE: begin
        half_nx   = 1'b1;
        credit_nx = credit - CRED_W'(1);
        reject_nx = pi_half | pi_one;
        if (credit == CRED_W'(1)) state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= ST_IDLE;
      credit    <= '0;
      po_cola   <= 1'b0;
      po_half   <= 1'b0;
      po_reject <= 1'b0;
    end else begin
      state     <= state_nx;
      credit    <= credit_nx;
      po_cola   <= cola_nx;
      po_half   <= half_nx;
      po_reject <= reject_nx;
    end
  end

  assign po_busy   = (state == ST_CHANGE);
  assign po_credit = credit;

  vend_sale_cnt #(.CNT_W(CNT_W)) u_sale_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .inc       (sale),
    .cnt       (po_sold_cnt)
  );

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed bench: expected outputs queued with each stimulus step, popped after the edge.
module tb_vend_fsm_param;

  typedef struct packed {
    logic        cola;
    logic        half;
    logic        reject;
    logic        busy;
    logic [3:0]  credit;
    logic [15:0] cnt;
  } obs_t;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic a_half = 1'b0, a_one = 1'b0, a_cancel = 1'b0;
  logic b_half = 1'b0, b_one = 1'b0, b_cancel = 1'b0;

  logic        a_cola, a_ohalf, a_reject, a_busy;
  logic [3:0]  a_credit;
  logic [15:0] a_cnt;
  logic        b_cola, b_ohalf, b_reject, b_busy;
  logic [3:0]  b_credit;
  logic [1:0]  b_cnt;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] sold_a = '0;
  logic [15:0] sold_b = '0;

  always #5 sys_clk = ~sys_clk;

  vend_fsm_param #(.PRICE(5), .CRED_W(4), .CNT_W(16)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_half(a_half), .pi_one(a_one), .pi_cancel(a_cancel),
    .po_cola(a_cola), .po_half(a_ohalf), .po_reject(a_reject),
    .po_busy(a_busy), .po_credit(a_credit), .po_sold_cnt(a_cnt)
  );

  vend_fsm_param #(.PRICE(1), .CRED_W(4), .CNT_W(2)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .pi_half(b_half), .pi_one(b_one), .pi_cancel(b_cancel),
    .po_cola(b_cola), .po_half(b_ohalf), .po_reject(b_reject),
    .po_busy(b_busy), .po_credit(b_credit), .po_sold_cnt(b_cnt)
  );

  function automatic obs_t mk(logic c, logic h, logic r, logic b, logic [3:0] cr, logic [15:0] n);
    obs_t o;
    o = '{cola: c, half: h, reject: r, busy: b, credit: cr, cnt: n};
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got);
    obs_t exp;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, got);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed cola=%b half=%b rej=%b busy=%b cr=%0d cnt=%0d, expected cola=%b half=%b rej=%b busy=%b cr=%0d cnt=%0d",
             tag, got.cola, got.half, got.reject, got.busy, got.credit, got.cnt,
             exp.cola, exp.half, exp.reject, exp.busy, exp.credit, exp.cnt);
    end
  endtask

  function automatic obs_t obs_a();
    return mk(a_cola, a_ohalf, a_reject, a_busy, a_credit, a_cnt);
  endfunction

  function automatic obs_t obs_b();
    return mk(b_cola, b_ohalf, b_reject, b_busy, b_credit, {14'd0, b_cnt});
  endfunction

  // Drive one cycle on DUT A and check the registered result after the edge.
  task automatic step_a(input string tag, input logic h, input logic o, input logic c,
                        input logic ec, input logic eh, input logic er, input logic eb,
                        input logic [3:0] ecr);
    @(negedge sys_clk);
    a_half = h; a_one = o; a_cancel = c;
    if (ec) sold_a = sold_a + 16'd1;
    exp_q.push_back(mk(ec, eh, er, eb, ecr, sold_a));
    @(posedge sys_clk);
    #1;
    a_half = 1'b0; a_one = 1'b0; a_cancel = 1'b0;
    check(tag, obs_a());
  endtask

  task automatic step_b(input string tag, input logic h, input logic ec);
    @(negedge sys_clk);
    b_half = h; b_one = 1'b0; b_cancel = 1'b0;
    if (ec) sold_b = (sold_b + 16'd1) & 16'h3;
    exp_q.push_back(mk(ec, 1'b0, 1'b0, 1'b0, 4'd0, sold_b));
    @(posedge sys_clk);
    #1;
    b_half = 1'b0;
    check(tag, obs_b());
  endtask

  initial begin
    // Reset state
    #2;
    exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 16'd0));
    check("reset_a", obs_a());
    exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 16'd0));
    check("reset_b", obs_b());
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Three 1-coins: sale with one half of change
    step_a("t1_one1",  0, 1, 0,  0, 0, 0, 0, 4'd2);
    step_a("t1_one2",  0, 1, 0,  0, 0, 0, 0, 4'd4);
    step_a("t1_one3",  0, 1, 0,  1, 0, 0, 1, 4'd1);
    step_a("t1_chg",   0, 0, 0,  0, 1, 0, 0, 4'd0);
    step_a("t1_idle",  0, 0, 0,  0, 0, 0, 0, 4'd0);

    // Five halves: exact price, never busy
    step_a("t2_h1",    1, 0, 0,  0, 0, 0, 0, 4'd1);
    step_a("t2_h2",    1, 0, 0,  0, 0, 0, 0, 4'd2);
    step_a("t2_h3",    1, 0, 0,  0, 0, 0, 0, 4'd3);
    step_a("t2_h4",    1, 0, 0,  0, 0, 0, 0, 4'd4);
    step_a("t2_h5",    1, 0, 0,  1, 0, 0, 0, 4'd0);
    step_a("t2_idle",  0, 0, 0,  0, 0, 0, 0, 4'd0);

    // n=7: two change pulses; coins during payout (incl. the exit edge) rejected
    step_a("t3_one1",  0, 1, 0,  0, 0, 0, 0, 4'd2);
    step_a("t3_one2",  0, 1, 0,  0, 0, 0, 0, 4'd4);
    step_a("t3_both",  1, 1, 0,  1, 0, 0, 1, 4'd2);
    step_a("t3_rej1",  0, 1, 0,  0, 1, 1, 1, 4'd1);
    step_a("t3_rej2",  1, 0, 0,  0, 1, 1, 0, 4'd0);
    step_a("t3_idle",  0, 0, 0,  0, 0, 0, 0, 4'd0);

    // Cancel with nothing inserted does nothing
    step_a("t4_cnl0",  0, 0, 1,  0, 0, 0, 0, 4'd0);
    // Cancel beats vending (total 5 == PRICE): five refund pulses
    step_a("t4_one",   0, 1, 0,  0, 0, 0, 0, 4'd2);
    step_a("t4_half",  1, 0, 0,  0, 0, 0, 0, 4'd3);
    step_a("t4_cnl",   0, 1, 1,  0, 0, 0, 1, 4'd5);
    step_a("t4_p1",    0, 0, 1,  0, 1, 0, 1, 4'd4);
    step_a("t4_p2",    0, 0, 0,  0, 1, 0, 1, 4'd3);
    step_a("t4_p3",    0, 0, 0,  0, 1, 0, 1, 4'd2);
    step_a("t4_p4",    0, 0, 0,  0, 1, 0, 1, 4'd1);
    step_a("t4_p5",    0, 0, 0,  0, 1, 0, 0, 4'd0);
    step_a("t4_idle",  0, 0, 0,  0, 0, 0, 0, 4'd0);

    // PRICE=1, CNT_W=2: counter wraps 3 -> 0 -> 1
    step_b("t5_b1", 1, 1);
    step_b("t5_b2", 1, 1);
    step_b("t5_b3", 1, 1);
    step_b("t5_b4", 1, 1);
    step_b("t5_b5", 1, 1);

    // Reset in the middle of a 3-pulse refund
    step_a("t6_one",   0, 1, 0,  0, 0, 0, 0, 4'd2);
    step_a("t6_half",  1, 0, 0,  0, 0, 0, 0, 4'd3);
    step_a("t6_cnl",   0, 0, 1,  0, 0, 0, 1, 4'd3);
    step_a("t6_p1",    0, 0, 0,  0, 1, 0, 1, 4'd2);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    sold_a = '0;
    sold_b = '0;
    exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 16'd0));
    check("t6_rst_a", obs_a());
    exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 16'd0));
    check("t6_rst_b", obs_b());
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    step_a("t6_post1", 0, 0, 0,  0, 0, 0, 0, 4'd0);
    step_a("t6_post2", 0, 0, 0,  0, 0, 0, 0, 4'd0);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
